// File: rtl/dmem_access_ctrl_if.sv
// Data memory bus: valid/ready request
// channel plus a valid-only response channel.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store sequencer onto a
// variable-latency data bus, with stall and errors.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  WidthSrcM,
  input  logic        StallExtM,
  dmem_access_ctrl_if.master bus,
  output logic [31:0] ReadDataM,
  output logic        StallMemM,
  output logic        MisalignM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t     state, nxt;
  logic [CNT_W-1:0] cnt;
  logic       is_byte, is_half;
  logic       mem_op, access;
  logic       tmo;
  logic [3:0] be;
  logic [31:0] wdata;
  logic [31:0] rshift;
  logic       unused_width;

  assign unused_width = WidthSrcM[2];

  assign is_byte = (WidthSrcM[1:0] == 2'b10);
  assign is_half = (WidthSrcM[1:0] == 2'b01);
  assign mem_op  = MemReadM | MemWriteM;

  assign MisalignM = mem_op & (is_half
    ? ALUResultM[0]
    : (~is_byte & (|ALUResultM[1:0])));

  assign access = mem_op & ~MisalignM;

  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    unique case (1'b1)
      is_byte: begin
        be    = 4'b0001 << ALUResultM[1:0];
        wdata = {4{WriteDataM[7:0]}};
      end
      is_half: begin
        be    = ALUResultM[1] ? 4'b1100
                              : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // pipeline holds the M-stage operands
  // while stalled, so these stay stable in REQ
  assign bus.req_valid = (state == REQ);
  assign bus.req_we    = MemWriteM & ~MemReadM;
  assign bus.req_addr  = {ALUResultM[31:2], 2'b00};
  assign bus.req_be    = be;
  assign bus.req_wdata = wdata;

  assign rshift = bus.resp_rdata
                  >> {ALUResultM[1:0], 3'b000};
  assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (access) nxt = REQ;
      REQ:
        if (bus.req_ready)
          nxt = bus.req_we ? DONE : WAIT;
      WAIT:
        if (bus.resp_valid || tmo) nxt = DONE;
      DONE: if (!StallExtM) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      if (state == IDLE && access)
        BusErrM <= 1'b0;
      if (state == REQ)
        cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
        // a response on the timeout cycle wins
        if (bus.resp_valid) begin
          ReadDataM <= rshift;
          BusErrM   <= 1'b0;
        end else if (tmo) begin
          ReadDataM <= '0;
          BusErrM   <= 1'b1;
        end
      end
    end
  end

  assign StallMemM = ((state == IDLE) & access)
                   | (state == REQ)
                   | (state == WAIT);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with
// hand-computed expectations.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  WidthSrcM;
  logic        StallExtM;
  logic [31:0] ReadDataM;
  logic        StallMemM, MisalignM, BusErrM;

  int checks = 0;
  int errors = 0;
  int writes;
  int waits;

  dmem_access_ctrl_if bus_if();

  dmem_access_ctrl #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .WidthSrcM (WidthSrcM),
    .StallExtM (StallExtM),
    .bus       (bus_if),
    .ReadDataM (ReadDataM),
    .StallMemM (StallMemM),
    .MisalignM (MisalignM),
    .BusErrM   (BusErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    WidthSrcM  = 3'b000;
    StallExtM  = 1'b0;
    bus_if.req_ready  = 1'b0;
    bus_if.resp_valid = 1'b0;
    bus_if.resp_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus_if.req_valid), 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_berr", 32'(BusErrM), 0);
    chk("rst_stall", 32'(StallMemM), 0);
    reset = 1'b1;

    // word load, zero-wait
    @(negedge clk);
    MemReadM   = 1'b1;
    ALUResultM = 32'h100;
    WidthSrcM  = 3'b000;
    bus_if.req_ready  = 1'b1;
    bus_if.resp_valid = 1'b1;
    bus_if.resp_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_idle_stall", 32'(StallMemM), 1);
    chk("t1_idle_valid", 32'(bus_if.req_valid), 0);
    @(negedge clk); #1;
    chk("t1_req_valid", 32'(bus_if.req_valid), 1);
    chk("t1_req_be", 32'(bus_if.req_be), 32'hF);
    chk("t1_req_addr", bus_if.req_addr, 32'h100);
    chk("t1_req_we", 32'(bus_if.req_we), 0);
    chk("t1_req_stall", 32'(StallMemM), 1);
    @(negedge clk); #1;
    chk("t1_wait_stall", 32'(StallMemM), 1);
    @(negedge clk); #1;
    chk("t1_done_stall", 32'(StallMemM), 0);
    chk("t1_rdata", ReadDataM, 32'hDEADBEEF);
    chk("t1_berr", 32'(BusErrM), 0);

    // byte store, ready delayed 4 cycles
    @(negedge clk);
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    ALUResultM = 32'h203;
    WriteDataM = 32'h000000AB;
    WidthSrcM  = 3'b010;
    bus_if.req_ready  = 1'b0;
    bus_if.resp_valid = 1'b0;
    writes = 0;
    #1;
    chk("t2_idle_stall", 32'(StallMemM), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t2_hold_valid",
          32'(bus_if.req_valid), 1);
      chk("t2_hold_addr",
          bus_if.req_addr, 32'h200);
      chk("t2_hold_be",
          32'(bus_if.req_be), 32'h8);
      chk("t2_hold_wdata",
          bus_if.req_wdata, 32'hABABABAB);
      chk("t2_hold_we",
          32'(bus_if.req_we), 1);
    end
    @(negedge clk);
    bus_if.req_ready = 1'b1;
    #1;
    if (bus_if.req_valid) writes++;
    // DONE held by external stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      StallExtM = 1'b1;
      #1;
      if (bus_if.req_valid) writes++;
      chk("t2_done_valid",
          32'(bus_if.req_valid), 0);
      chk("t2_done_stall",
          32'(StallMemM), 0);
    end
    @(negedge clk);
    StallExtM = 1'b0;
    #1;
    if (bus_if.req_valid) writes++;
    chk("t2_writes", 32'(writes), 1);

    // half load at upper half
    @(negedge clk);
    MemWriteM  = 1'b0;
    MemReadM   = 1'b1;
    ALUResultM = 32'h302;
    WidthSrcM  = 3'b001;
    bus_if.req_ready  = 1'b1;
    bus_if.resp_valid = 1'b1;
    bus_if.resp_rdata = 32'h12345678;
    #1;
    chk("t3_misalign", 32'(MisalignM), 0);
    @(negedge clk); #1;
    chk("t3_be", 32'(bus_if.req_be), 32'hC);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t3_rdata", ReadDataM, 32'h00001234);
    chk("t3_stall", 32'(StallMemM), 0);

    // misaligned word and half
    @(negedge clk);
    WidthSrcM  = 3'b000;
    ALUResultM = 32'h101;
    #1;
    chk("t4_misalign", 32'(MisalignM), 1);
    chk("t4_valid", 32'(bus_if.req_valid), 0);
    chk("t4_stall", 32'(StallMemM), 0);
    @(negedge clk); #1;
    chk("t4_valid2", 32'(bus_if.req_valid), 0);
    chk("t4_stall2", 32'(StallMemM), 0);
    WidthSrcM  = 3'b001;
    ALUResultM = 32'h303;
    #1;
    chk("t4_half_mis", 32'(MisalignM), 1);

    // read timeout
    @(negedge clk);
    WidthSrcM  = 3'b000;
    ALUResultM = 32'h400;
    bus_if.resp_valid = 1'b0;
    @(negedge clk);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!StallMemM) break;
      waits++;
    end
    chk("t5_waits", 32'(waits), 4);
    chk("t5_stall", 32'(StallMemM), 0);
    chk("t5_rdata", ReadDataM, 0);
    chk("t5_berr", 32'(BusErrM), 1);
    @(negedge clk);
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    ALUResultM = 32'h500;
    WriteDataM = 32'h11223344;
    #1;
    chk("t5_berr_idle", 32'(BusErrM), 1);
    @(negedge clk); #1;
    chk("t5_berr_clr", 32'(BusErrM), 0);
    chk("t5_wdata",
        bus_if.req_wdata, 32'h11223344);
    @(negedge clk); #1;
    chk("t5_wr_stall", 32'(StallMemM), 0);

    // response on the timeout cycle wins
    @(negedge clk);
    MemWriteM  = 1'b0;
    MemReadM   = 1'b1;
    ALUResultM = 32'h600;
    bus_if.resp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus_if.resp_valid = 1'b1;
    #1;
    chk("t5b_stall", 32'(StallMemM), 1);
    @(negedge clk);
    bus_if.resp_valid = 1'b0;
    #1;
    chk("t5b_rdata", ReadDataM, 32'hCAFEF00D);
    chk("t5b_berr", 32'(BusErrM), 0);
    chk("t5b_dstall", 32'(StallMemM), 0);

    // reset during WAIT
    @(negedge clk);
    ALUResultM = 32'h700;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_wait_stall", 32'(StallMemM), 1);
    @(negedge clk);
    reset    = 1'b0;
    MemReadM = 1'b0;
    #1;
    chk("t6_rst_valid",
        32'(bus_if.req_valid), 0);
    chk("t6_rst_rdata", ReadDataM, 0);
    chk("t6_rst_berr", 32'(BusErrM), 0);
    chk("t6_rst_stall", 32'(StallMemM), 0);
    @(negedge clk);
    reset = 1'b1;
    bus_if.resp_valid = 1'b1;
    bus_if.resp_rdata = 32'h55555555;
    @(negedge clk); #1;
    chk("t6_late_rdata", ReadDataM, 0);
    chk("t6_late_valid",
        32'(bus_if.req_valid), 0);
    chk("t6_late_stall", 32'(StallMemM), 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences memory-stage loads and stores onto a variable-latency data memory bus with a valid/ready request channel and a valid response channel.
- Generates byte enables and lane-replicated write data from width and address.
- Captures read data and right-aligns it, so downstream width reduction operates on the low bits.
- Asserts a stall toward the hazard unit until each access completes, and flags misaligned and timed-out accesses.

Parameters:
- TIMEOUT, 255: maximum cycles in WAIT before the access aborts with a bus error. Minimum 1.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  memory-stage instruction is a load.
- MemWriteM  in  1  memory-stage instruction is a store.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- WidthSrcM  in  3  [1:0] 00=word, 01=half, 10=byte, 11 is treated as word; [2] unused here.
- StallExtM  in  1  memory-stage stall from the hazard unit, excluding this block's stall.
- req_valid  out  1  bus request valid.
- req_we  out  1  1=write, 0=read.
- req_addr  out  32  {ALUResultM[31:2],2'b00}.
- req_wdata  out  32  lane-replicated write data.
- req_be  out  4  byte enables.
- req_ready  in  1  bus accepts the request.
- resp_valid  in  1  read data valid.
- resp_rdata  in  32  read data.
- ReadDataM  out  32  captured, right-shifted read data.
- StallMemM  out  1  stall request to the hazard unit.
- MisalignM  out  1  misaligned access in the memory stage (combinational).
- BusErrM  out  1  last load timed out; registered, held until the next access starts.

Behaviour:
- Access condition: access = (MemReadM | MemWriteM) & ~MisalignM. If MemReadM and MemWriteM are both high, the access is a read.
- Misalignment:
  - Word access: MisalignM = (addr[1:0] != 0).
  - Half access: MisalignM = addr[0].
  - A misaligned access issues no request and raises no stall.
- Byte enables:
  - Byte: req_be = 4'b0001 << addr[1:0].
  - Half: req_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: req_be = 4'b1111.
  - Read requests drive the same req_be.
- Write data: byte = {4{wd[7:0]}}, half = {2{wd[15:0]}}, word = wd.
- States: IDLE, REQ, WAIT, DONE.
- Transitions:
  - IDLE: if access, go to REQ. req_valid is not driven in IDLE.
  - REQ: req_valid=1, with req_we/req_addr/req_be/req_wdata stable until accepted. On req_ready: a write goes to DONE (posted); a read goes to WAIT with the counter cleared.
  - WAIT: counter increments each cycle.
    - resp_valid: ReadDataM <= resp_rdata >> (8*addr[1:0]), zero-filled; BusErrM <= 0; go to DONE.
    - Counter reaches TIMEOUT without resp_valid: ReadDataM <= 0, BusErrM <= 1, go to DONE.
    - resp_valid in the same cycle as the timeout takes priority: data is captured, no error.
  - DONE: remains while StallExtM=1. Goes to IDLE once StallExtM=0, the cycle the pipeline advances.
- A response arriving in WAIT on the same cycle the request was accepted is not possible: WAIT is entered only after acceptance.
- resp_valid outside WAIT is ignored.
- StallMemM = (IDLE & access) | REQ | WAIT. It is 0 in DONE, so the held instruction retires exactly once and is never reissued.
- The minimum read is 3 stalled cycles (IDLE, REQ, WAIT) with zero-wait ready and response.
- BusErrM clears on the IDLE-to-REQ transition.
- Reset (asynchronous, any state): state=IDLE, req_valid=0, ReadDataM=0, BusErrM=0, counter=0.
  - After reset deasserts, an access still present in the memory stage restarts from IDLE.
  - A bus transaction in flight at reset is abandoned, and its late response is ignored.

Test Plan:
- Word load at addr 0x100, ready and response 0xDEADBEEF both zero-wait -> req_be=1111, StallMemM high for 3 cycles, ReadDataM=0xDEADBEEF, BusErrM=0.
- Byte store 0xAB at addr 0x203, req_ready delayed 4 cycles -> req_addr=0x200, req_be=1000, req_wdata=0xABABABAB held for all 4 cycles; DONE follows; a single write occurs.
- Half load at addr 0x302 with resp_rdata=0x12345678 -> req_be=1100, ReadDataM=0x00001234.
- Word load at addr 0x101 -> MisalignM=1, req_valid stays 0, StallMemM=0.
- Read with no response and TIMEOUT=4 -> ReadDataM=0, BusErrM=1, StallMemM drops; the next access clears BusErrM.
- StallExtM held for 3 cycles in DONE -> no reissue and req_valid stays 0. Separately, reset asserted in WAIT -> IDLE immediately, outputs at reset values, a subsequent resp_valid ignored.
